time_set_controller: RTL and testbench

//  Front-panel controller for the 24h time counter (hours 0-23, min/sec 0-59) in the clock system.

---
 rtl/clock_sys_pkg.sv | 54 +++++
 rtl/time_set_controller_if.sv | 28 ++
 rtl/button_sync_edge.sv | 75 +++++++
 rtl/time_set_controller.sv | 162 ++++++++++++++++
 tb/tb_time_set_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_sys_pkg.sv
// Shared types and constants for the clock-system front panel.
// Optional feature macro used by the controller: AUTO_REPEAT_EN.
package clock_sys_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_EDIT_HR,
        ST_EDIT_MIN,
        ST_EDIT_SEC,
        ST_COMMIT
    } state_e;

    // field_sel codes
    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    // Display mode codes; only the clock mode allows entering edit
    localparam logic [1:0] MODE_CLOCK = 2'd0;

    // Button slots in the synchronizer array
    localparam int NUM_BTNS = 4;
    localparam int BTN_MODE = 0;
    localparam int BTN_SET  = 1;
    localparam int BTN_OP1  = 2;
    localparam int BTN_OP2  = 3;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
    } hms_t;

    function automatic logic is_edit_state(input state_e s);
        return (s == ST_EDIT_HR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
    endfunction

    // Hours step with 23 <-> 0 wrap
    function automatic logic [4:0] step_hr(input logic [4:0] v, input logic up);
        if (up) return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? HOUR_MAX : v - 5'd1;
    endfunction

    // Minutes/seconds step with 59 <-> 0 wrap
    function automatic logic [5:0] step_ms(input logic [5:0] v, input logic up);
        if (up) return (v >= MINSEC_MAX) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? MINSEC_MAX : v - 6'd1;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Front-panel bus: raw buttons and running time in, display/edit state and load strobe out.
interface time_set_controller_if;
    logic       mode;
    logic       set;
    logic       op1;
    logic       op2;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic [1:0] cur_mode;
    logic       editing;
    logic [1:0] field_sel;
    logic       blink;
    logic       ld_en;
    logic [4:0] ld_hours;
    logic [5:0] ld_minutes;
    logic [5:0] ld_seconds;

    modport master (
        output mode, set, op1, op2, cur_hours, cur_minutes, cur_seconds,
        input  cur_mode, editing, field_sel, blink, ld_en, ld_hours, ld_minutes, ld_seconds
    );

    modport slave (
        input  mode, set, op1, op2, cur_hours, cur_minutes, cur_seconds,
        output cur_mode, editing, field_sel, blink, ld_en, ld_hours, ld_minutes, ld_seconds
    );
endinterface

// File: rtl/button_sync_edge.sv
// One front-panel button: 2-flop synchronizer, rising-edge detect and a registered
// one-cycle press pulse. With AUTO_REPEAT_EN defined, a held button (while rpt_en_i)
// also emits repeat pulses after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
module button_sync_edge
`ifdef AUTO_REPEAT_EN
#(
    parameter logic [31:0] REPEAT_DELAY  = 32'd25_000_000,
    parameter logic [31:0] REPEAT_PERIOD = 32'd5_000_000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
`ifdef AUTO_REPEAT_EN
    input  logic rpt_en_i,
`endif
    output logic press_o
);

    logic [1:0] sync_q;
    logic       lvl_prev_q;
    logic       press_q;
    logic       fire;

`ifdef AUTO_REPEAT_EN
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_armed_q, rpt_armed_d;

    // Held-cycle counter: first target is the delay, then the period once armed
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        fire        = 1'b0;
        if (sync_q[1] && rpt_en_i) begin
            rpt_armed_d = rpt_armed_q;
            rpt_cnt_d   = rpt_cnt_q + 32'd1;
            if (rpt_cnt_q == (rpt_armed_q ? REPEAT_PERIOD : REPEAT_DELAY) - 32'd1) begin
                fire        = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end
        end
    end

    // Repeat counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign fire = 1'b0;
`endif

    // Synchronizer, edge history and registered press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_i};
            lvl_prev_q <= sync_q[1];
            press_q    <= (sync_q[1] & ~lvl_prev_q) | fire;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel time-set controller: display-mode cycling and HH->MM->SS editing of a
// shadow copy of the running time, committed to the counter with a one-cycle ld_en.
// Optional feature macro: AUTO_REPEAT_EN (held op1/op2 auto-repeat while editing).
module time_set_controller
    import clock_sys_pkg::*;
#(
    parameter int unsigned NUM_MODES      = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000 * 32'd30,
    parameter logic [31:0] BLINK_CYCLES   = 32'd25_000_000
`ifdef AUTO_REPEAT_EN
   ,parameter logic [31:0] REPEAT_DELAY   = 32'd25_000_000,
    parameter logic [31:0] REPEAT_PERIOD  = 32'd5_000_000
`endif
)(
    input  logic clk,
    input  logic reset,
    time_set_controller_if.slave bus
);

    localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;
    state_e      state_q, state_d;
    logic [1:0]  cur_mode_q, cur_mode_d;
    hms_t        shadow_q, shadow_d;
    hms_t        ld_q, ld_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        do_mode, do_set, do_inc, do_dec;
    logic        in_edit, nxt_edit, tmo_hit;

    assign btn_raw = {bus.op2, bus.op1, bus.set, bus.mode};

`ifdef AUTO_REPEAT_EN
    logic [NUM_BTNS-1:0] rpt_en;
    assign rpt_en = {in_edit, in_edit, 2'b00};
`endif

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_sync_edge
`ifdef AUTO_REPEAT_EN
        #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
`endif
        u_btn (
            .clk     (clk),
            .rst_n   (reset),
            .btn_i   (btn_raw[i]),
`ifdef AUTO_REPEAT_EN
            .rpt_en_i(rpt_en[i]),
`endif
            .press_o (press[i])
        );
    end

    // Same-cycle priority mode > set > op; op1 together with op2 cancels both
    assign do_mode = press[BTN_MODE];
    assign do_set  = press[BTN_SET] & ~do_mode;
    assign do_inc  = press[BTN_OP1] & ~press[BTN_OP2] & ~do_mode & ~do_set;
    assign do_dec  = press[BTN_OP2] & ~press[BTN_OP1] & ~do_mode & ~do_set;

    assign in_edit  = is_edit_state(state_q);
    assign nxt_edit = is_edit_state(state_d);
    assign tmo_hit  = (tmo_q == TIMEOUT_CYCLES - 32'd1);

    // Next state, display mode, shadow edits and commit capture
    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        shadow_d   = shadow_q;
        ld_d       = ld_q;
        case (state_q)
            ST_RUN: begin
                if (do_mode) begin
                    cur_mode_d = (cur_mode_q == MODE_LAST) ? MODE_CLOCK : cur_mode_q + 2'd1;
                end else if (do_set && cur_mode_q == MODE_CLOCK) begin
                    shadow_d = '{hr: bus.cur_hours, mn: bus.cur_minutes, sc: bus.cur_seconds};
                    state_d  = ST_EDIT_HR;
                end
            end
            ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
                if (do_mode || tmo_hit) begin
                    state_d = ST_RUN;
                end else if (do_set) begin
                    case (state_q)
                        ST_EDIT_HR:  state_d = ST_EDIT_MIN;
                        ST_EDIT_MIN: state_d = ST_EDIT_SEC;
                        default: begin
                            state_d = ST_COMMIT;
                            ld_d    = shadow_q;
                        end
                    endcase
                end else if (do_inc || do_dec) begin
                    case (state_q)
                        ST_EDIT_HR:  shadow_d.hr = step_hr(shadow_q.hr, do_inc);
                        ST_EDIT_MIN: shadow_d.mn = step_ms(shadow_q.mn, do_inc);
                        default:     shadow_d.sc = step_ms(shadow_q.sc, do_inc);
                    endcase
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Idle timeout and blink phase: both restart on edit entry and field change
    always_comb begin
        tmo_d       = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (nxt_edit && state_d == state_q) begin
            tmo_d = (|press) ? '0 : tmo_q + 32'd1;
            if (blink_cnt_q == BLINK_CYCLES - 32'd1) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
                blink_d     = blink_q;
            end
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cur_mode_q  <= MODE_CLOCK;
            shadow_q    <= '0;
            ld_q        <= '0;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_mode_q  <= cur_mode_d;
            shadow_q    <= shadow_d;
            ld_q        <= ld_d;
            tmo_q       <= tmo_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Field indicator follows the edit state
    always_comb begin
        case (state_q)
            ST_EDIT_HR:  bus.field_sel = FIELD_HR;
            ST_EDIT_MIN: bus.field_sel = FIELD_MIN;
            ST_EDIT_SEC: bus.field_sel = FIELD_SEC;
            default:     bus.field_sel = FIELD_NONE;
        endcase
    end

    assign bus.cur_mode   = cur_mode_q;
    assign bus.editing    = in_edit;
    assign bus.blink      = blink_q;
    assign bus.ld_en      = (state_q == ST_COMMIT);
    assign bus.ld_hours   = ld_q.hr;
    assign bus.ld_minutes = ld_q.mn;
    assign bus.ld_seconds = ld_q.sc;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller (timeout/blink shortened to 100/8 cycles).
module tb_time_set_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ld_cnt = 0;
    logic [16:0] ld_seen = '0;

    always #5 clk = ~clk;

    time_set_controller_if bus();

    time_set_controller #(
        .NUM_MODES     (4),
        .TIMEOUT_CYCLES(32'd100),
        .BLINK_CYCLES  (32'd8)
`ifdef AUTO_REPEAT_EN
       ,.REPEAT_DELAY  (32'd20),
        .REPEAT_PERIOD (32'd5)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Record every load strobe and the value presented with it
    always @(negedge clk) begin
        if (bus.ld_en) begin
            ld_cnt  <= ld_cnt + 1;
            ld_seen <= {bus.ld_hours, bus.ld_minutes, bus.ld_seconds};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.cur_hours = h; bus.cur_minutes = m; bus.cur_seconds = s;
    endtask

    // b: 0 mode, 1 set, 2 op1, 3 op2, 4 op1+op2 together
    task automatic press(input int b);
        @(negedge clk);
        case (b)
            0: bus.mode = 1'b1;
            1: bus.set  = 1'b1;
            2: bus.op1  = 1'b1;
            3: bus.op2  = 1'b1;
            default: begin bus.op1 = 1'b1; bus.op2 = 1'b1; end
        endcase
        @(negedge clk);
        bus.mode = 1'b0; bus.set = 1'b0; bus.op1 = 1'b0; bus.op2 = 1'b0;
        tick(6);
    endtask

    task automatic test_reset;
        int n0;
        reset = 1'b0;
        bus.mode = 1'b0; bus.set = 1'b0; bus.op1 = 1'b0; bus.op2 = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
        tick(3);
        checks++;
        if ({bus.cur_mode, bus.editing, bus.field_sel, bus.blink, bus.ld_en} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0",
                {bus.cur_mode, bus.editing, bus.field_sel, bus.blink, bus.ld_en});
        end
        checks++;
        if ({bus.ld_hours, bus.ld_minutes, bus.ld_seconds} !== 17'd0) begin
            errors++; $display("FAIL reset_ld: got %h expected 0",
                {bus.ld_hours, bus.ld_minutes, bus.ld_seconds});
        end
        reset = 1'b1;
        tick(2);
        press(0);
        checks++;
        if (bus.cur_mode !== 2'd1) begin
            errors++; $display("FAIL pre_reset_mode: got %0d expected 1", bus.cur_mode);
        end
        @(negedge clk); #2 reset = 1'b0; #1;
        checks++;
        if (bus.cur_mode !== 2'd0) begin
            errors++; $display("FAIL async_reset_mode: got %0d expected 0", bus.cur_mode);
        end
        @(negedge clk); reset = 1'b1;
        tick(2);
        set_time(5'd12, 6'd34, 6'd56);
        n0 = ld_cnt;
        press(1);
        press(2);
        checks++;
        if (bus.editing !== 1'b1 || bus.field_sel !== 2'd1) begin
            errors++; $display("FAIL edit_entry: got editing=%b fs=%0d expected 1/1",
                bus.editing, bus.field_sel);
        end
        @(negedge clk); #2 reset = 1'b0; #1;
        checks++;
        if (bus.editing !== 1'b0 || bus.field_sel !== 2'd0 || bus.blink !== 1'b0) begin
            errors++; $display("FAIL reset_mid_edit: got editing=%b fs=%0d blink=%b expected 0",
                bus.editing, bus.field_sel, bus.blink);
        end
        @(negedge clk); reset = 1'b1;
        tick(6);
        checks++;
        if (ld_cnt !== n0 || bus.ld_hours !== 5'd0) begin
            errors++; $display("FAIL reset_no_load: got strobes=%0d ld_h=%0d expected %0d/0",
                ld_cnt, bus.ld_hours, n0);
        end
    endtask

    task automatic test_mode_cycle;
        int exp_modes[5] = '{1, 2, 3, 0, 1};
        int n0;
        n0 = ld_cnt;
        for (int i = 0; i < 5; i++) begin
            press(0);
            checks++;
            if (bus.cur_mode !== 2'(exp_modes[i])) begin
                errors++; $display("FAIL mode_step%0d: got %0d expected %0d",
                    i, bus.cur_mode, exp_modes[i]);
            end
        end
        press(1);  // set outside clock mode is ignored
        checks++;
        if (bus.editing !== 1'b0 || ld_cnt !== n0) begin
            errors++; $display("FAIL mode_set_ignored: got editing=%b strobes=%0d expected 0/%0d",
                bus.editing, ld_cnt, n0);
        end
        for (int i = 0; i < 3; i++) press(0);
        checks++;
        if (bus.cur_mode !== 2'd0) begin
            errors++; $display("FAIL mode_back_to_clock: got %0d expected 0", bus.cur_mode);
        end
    endtask

    task automatic test_edit_commit;
        int n0;
        int exp_fs[4] = '{1, 2, 3, 0};
        logic [1:0] fs[4];
        n0 = ld_cnt;
        set_time(5'd23, 6'd59, 6'd58);
        press(1); fs[0] = bus.field_sel;
        set_time(5'd0, 6'd0, 6'd0);  // running time moves on; shadow must not follow
        press(2);
        press(1); fs[1] = bus.field_sel;
        press(3);
        press(1); fs[2] = bus.field_sel;
        press(2);
        press(1); fs[3] = bus.field_sel;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fs[i] !== 2'(exp_fs[i])) begin
                errors++; $display("FAIL commit_field_sel%0d: got %0d expected %0d",
                    i, fs[i], exp_fs[i]);
            end
        end
        checks++;
        if (ld_cnt !== n0 + 1) begin
            errors++; $display("FAIL commit_strobe_count: got %0d expected %0d", ld_cnt - n0, 1);
        end
        checks++;
        if (ld_seen !== {5'd0, 6'd58, 6'd59}) begin
            errors++; $display("FAIL commit_value: got %0d:%0d:%0d expected 0:58:59",
                ld_seen[16:12], ld_seen[11:6], ld_seen[5:0]);
        end
    endtask

    task automatic test_wrap_down;
        int n0;
        n0 = ld_cnt;
        set_time(5'd0, 6'd0, 6'd0);
        press(1); press(3);
        press(1); press(3);
        press(1); press(3);
        press(4);  // op1+op2 in the same cycle: no change
        press(1);
        checks++;
        if (ld_cnt !== n0 + 1) begin
            errors++; $display("FAIL wrap_strobe_count: got %0d expected 1", ld_cnt - n0);
        end
        checks++;
        if (ld_seen !== {5'd23, 6'd59, 6'd59}) begin
            errors++; $display("FAIL wrap_value: got %0d:%0d:%0d expected 23:59:59",
                ld_seen[16:12], ld_seen[11:6], ld_seen[5:0]);
        end
    endtask

    task automatic test_abort_timeout;
        int n0;
        int n;
        int blink_n;
        n0 = ld_cnt;
        set_time(5'd1, 6'd2, 6'd3);
        press(1); press(2); press(2);
        press(0);
        checks++;
        if (bus.editing !== 1'b0 || bus.field_sel !== 2'd0 || bus.cur_mode !== 2'd0) begin
            errors++; $display("FAIL abort_state: got editing=%b fs=%0d mode=%0d expected 0/0/0",
                bus.editing, bus.field_sel, bus.cur_mode);
        end
        checks++;
        if (ld_cnt !== n0 || {bus.ld_hours, bus.ld_minutes, bus.ld_seconds} !== {5'd23, 6'd59, 6'd59}) begin
            errors++; $display("FAIL abort_no_load: got strobes=%0d ld=%0d:%0d:%0d expected %0d 23:59:59",
                ld_cnt, bus.ld_hours, bus.ld_minutes, bus.ld_seconds, n0);
        end
        // Enter edit and leave it idle
        @(negedge clk); bus.set = 1'b1;
        @(negedge clk); bus.set = 1'b0;
        for (int w = 0; w < 10 && !bus.editing; w++) @(negedge clk);
        checks++;
        if (bus.editing !== 1'b1 || bus.blink !== 1'b0) begin
            errors++; $display("FAIL timeout_entry: got editing=%b blink=%b expected 1/0",
                bus.editing, bus.blink);
        end
        n = 0;
        blink_n = -1;
        while (bus.editing && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.blink && blink_n < 0) blink_n = n;
        end
        checks++;
        if (blink_n !== 8) begin
            errors++; $display("FAIL blink_first_toggle: got %0d expected 8", blink_n);
        end
        checks++;
        if (n !== 100) begin
            errors++; $display("FAIL timeout_cycles: got %0d expected 100", n);
        end
        checks++;
        if (ld_cnt !== n0 || bus.field_sel !== 2'd0 || bus.blink !== 1'b0) begin
            errors++; $display("FAIL timeout_no_load: got strobes=%0d fs=%0d blink=%b expected %0d/0/0",
                ld_cnt, bus.field_sel, bus.blink, n0);
        end
    endtask

    task automatic test_hold_repeat;
        int n0;
        logic [5:0] exp_min;
`ifdef AUTO_REPEAT_EN
        exp_min = 6'd16;
`else
        exp_min = 6'd11;
`endif
        n0 = ld_cnt;
        set_time(5'd5, 6'd10, 6'd20);
        press(1); press(1);
        checks++;
        if (bus.field_sel !== 2'd2) begin
            errors++; $display("FAIL hold_field: got %0d expected 2", bus.field_sel);
        end
        @(negedge clk); bus.op1 = 1'b1;
        repeat (40) @(negedge clk);
        bus.op1 = 1'b0;
        tick(6);
        press(1); press(1);
        checks++;
        if (ld_cnt !== n0 + 1) begin
            errors++; $display("FAIL hold_strobe_count: got %0d expected 1", ld_cnt - n0);
        end
        checks++;
        if (ld_seen !== {5'd5, exp_min, 6'd20}) begin
            errors++; $display("FAIL hold_value: got %0d:%0d:%0d expected 5:%0d:20",
                ld_seen[16:12], ld_seen[11:6], ld_seen[5:0], exp_min);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode_cycle();
        test_edit_commit();
        test_wrap_down();
        test_abort_timeout();
        test_hold_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
